// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the PC fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    ISSUE   = 2'd2,
    RESOLVE = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic       PC_SRC_SEQ = 1'b0;
  localparam logic       PC_SRC_BR  = 1'b1;

  function automatic logic is_branch(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - imem fetch, decode handshake and branch outcome bundle
interface pc_fetch_sequencer_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            br_valid;
  logic            br_taken;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_ready, br_valid, br_taken
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_ready, br_valid, br_taken
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts fetch wait cycles, flags the cycle that reaches TIMEOUT
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic areset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (areset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the waiting cycle whose increment would bring the count to TIMEOUT.
  assign o_expired = i_inc && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - sequences instruction fetch, decode handoff and PC update pulses
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 en,
  input  logic [XLEN-1:0]      pc_in,
  pc_fetch_sequencer_if.master bus,
  output logic                 pc_load,
  output logic                 pc_src,
  output logic                 fetch_err,
  output logic [CNT_W-1:0]     retired_cnt
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_fetch_err;
  logic [CNT_W-1:0] r_retired;

  logic w_wait_inc;
  logic w_expired;
  logic w_is_branch;
  logic w_issue_fire;
  logic w_resolve_fire;
  logic w_pc_load;

  assign w_wait_inc     = (r_state == FETCH) && !bus.imem_ready;
  assign w_is_branch    = is_branch(r_instr[6:0]);
  assign w_issue_fire   = (r_state == ISSUE) && bus.instr_ready;
  assign w_resolve_fire = (r_state == RESOLVE) && bus.br_valid;
  // The load pulse coincides with the accepting handshake so the next FETCH sees the new PC.
  assign w_pc_load      = (w_issue_fire && !w_is_branch) || w_resolve_fire;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .areset    (areset),
    .i_clr     (!w_wait_inc),
    .i_inc     (w_wait_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_fetch_err <= 1'b0;
      r_retired   <= '0;
    end else begin
      if (w_pc_load) begin
        r_retired <= r_retired + 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (en && !r_fetch_err) r_state <= FETCH;
        end
        FETCH: begin
          if (bus.imem_ready) begin
            r_instr    <= bus.imem_rdata;
            r_instr_pc <= pc_in;
            r_state    <= ISSUE;
          end else if (w_expired) begin
            r_fetch_err <= 1'b1;
            r_state     <= IDLE;
          end
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            if (w_is_branch) r_state <= RESOLVE;
            else             r_state <= en ? FETCH : IDLE;
          end
        end
        RESOLVE: begin
          if (bus.br_valid) r_state <= en ? FETCH : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = (r_state == FETCH);
  assign bus.imem_addr   = (r_state == FETCH) ? pc_in : '0;
  assign bus.instr_valid = (r_state == ISSUE);
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;

  assign pc_load     = w_pc_load;
  assign pc_src      = (w_resolve_fire && bus.br_taken) ? PC_SRC_BR : PC_SRC_SEQ;
  assign fetch_err   = r_fetch_err;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] BR_OFF = 32'h0000_0040;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ    = 32'h0020_8463;
  localparam logic [6:0]  BR_OPC = 7'b1100011;

  logic        clk = 1'b0;
  logic        areset;
  logic        en;
  logic [31:0] pc_in;
  logic        pc_load;
  logic        pc_src;
  logic        fetch_err;
  logic [3:0]  retired_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.XLEN(32)) bus ();

  pc_fetch_sequencer #(
    .XLEN    (32),
    .TIMEOUT (16),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .en          (en),
    .pc_in       (pc_in),
    .bus         (bus),
    .pc_load     (pc_load),
    .pc_src      (pc_src),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  task automatic fill_mem(input int br_pct);
    logic [31:0] r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom();
      if (int'($urandom_range(0, 99)) < br_pct) mem[i] = {r[31:7], BR_OPC};
      else                                      mem[i] = {r[31:7], 7'b0010011};
    end
  endtask

  // Bench-side program counter: follows pc_load/pc_src, sampled before the edge.
  task automatic tick();
    logic ld, src;
    ld  = pc_load;
    src = pc_src;
    @(posedge clk);
    #1;
    if (ld === 1'b1) pc_in = pc_in + (src ? BR_OFF : 32'd4);
    bus.imem_rdata = word_at(pc_in);
    @(negedge clk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    en = 1'b0;
    bus.imem_ready = 1'b0;
    bus.instr_ready = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_taken = 1'b0;
    pc_in = BASE;
    bus.imem_rdata = word_at(BASE);
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem(30);
    do_reset();
    #1;
    if ({bus.imem_req, bus.instr_valid, pc_load, pc_src, fetch_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {bus.imem_req, bus.instr_valid, pc_load, pc_src, fetch_err});
    end
    checks++;
    if ({bus.instr, bus.instr_pc, bus.imem_addr} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {bus.instr, bus.instr_pc, bus.imem_addr});
    end
    checks++;
    if (retired_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_retired got %0d exp 0", retired_cnt);
    end
    checks++;
    en = 1'b1;
    tick();
    #1;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== BASE) begin
      errors++; $display("FAIL reset_first_fetch got req %b addr %h exp 1 %h", bus.imem_req, bus.imem_addr, BASE);
    end
    checks++;
  endtask

  task automatic test_stream();
    int loads, last, first, gap_bad, src_bad;
    loads = 0; last = -1; first = -1; gap_bad = 0; src_bad = 0;
    fill_mem(0);
    do_reset();
    en = 1'b1; bus.imem_ready = 1'b1; bus.instr_ready = 1'b1;
    for (int c = 0; c < 40 && loads < 4; c++) begin
      #1;
      if (pc_load === 1'b1) begin
        if (first < 0) first = c;
        if (last >= 0 && c - last != 2) gap_bad++;
        if (pc_src !== 1'b0) src_bad++;
        last = c;
        loads++;
      end
      tick();
    end
    if (loads != 4) begin errors++; $display("FAIL stream_loads got %0d exp 4", loads); end
    checks++;
    if (first != 2) begin errors++; $display("FAIL stream_first_load got cycle %0d exp 2", first); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL stream_gap got %0d bad gaps exp 0", gap_bad); end
    checks++;
    if (src_bad != 0) begin errors++; $display("FAIL stream_src got %0d nonzero exp 0", src_bad); end
    checks++;
    if (retired_cnt !== 4'd4) begin errors++; $display("FAIL stream_retired got %0d exp 4", retired_cnt); end
    checks++;
  endtask

  task automatic test_imem_delay();
    logic [31:0] p0;
    int bad, held;
    bad = 0; held = 0;
    fill_mem(0);
    do_reset();
    en = 1'b1;
    tick();
    p0 = pc_in;
    for (int k = 0; k < 4; k++) begin
      bus.imem_ready = (k == 3);
      bus.imem_rdata = (k == 3) ? word_at(p0) : 32'hDEAD_BEEF;
      #1;
      if (bus.imem_req === 1'b1) held++;
      if (bus.imem_addr !== p0) bad++;
      tick();
    end
    bus.imem_ready = 1'b0;
    #1;
    if (held != 4 || bad != 0) begin
      errors++; $display("FAIL delay_req_hold got %0d cycles %0d addr errs exp 4 0", held, bad);
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== word_at(p0) || bus.instr_pc !== p0) begin
      errors++; $display("FAIL delay_capture got v %b %h @%h exp 1 %h @%h", bus.instr_valid, bus.instr, bus.instr_pc, word_at(p0), p0);
    end
    checks++;
    if (fetch_err !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL delay_err got err %b req %b exp 0 0", fetch_err, bus.imem_req);
    end
    checks++;
  endtask

  task automatic test_timeout();
    int n, woke;
    n = 0; woke = 0;
    fill_mem(0);
    do_reset();
    en = 1'b1;
    tick();
    #1;
    while (bus.imem_req === 1'b1 && n < 40) begin
      n++;
      tick();
      #1;
    end
    if (n != 16) begin errors++; $display("FAIL timeout_cycles got %0d exp 16", n); end
    checks++;
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", fetch_err); end
    checks++;
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || fetch_err !== 1'b1) woke++;
    end
    if (woke != 0) begin errors++; $display("FAIL timeout_sticky got %0d active cycles exp 0", woke); end
    checks++;
    do_reset();
    #1;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", fetch_err); end
    checks++;
  endtask

  task automatic test_branch();
    fill_mem(0);
    mem[BASE[7:2]] = BEQ;
    do_reset();
    en = 1'b1; bus.imem_ready = 1'b1; bus.instr_ready = 1'b1;
    tick();
    tick();
    #1;
    if (bus.instr_valid !== 1'b1 || bus.instr !== BEQ || pc_load !== 1'b0) begin
      errors++; $display("FAIL branch_issue got v %b %h load %b exp 1 %h 0", bus.instr_valid, bus.instr, pc_load, BEQ);
    end
    checks++;
    tick();
    #1;
    if (bus.instr_valid !== 1'b0 || pc_load !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL branch_wait got v %b load %b req %b exp 0 0 0", bus.instr_valid, pc_load, bus.imem_req);
    end
    checks++;
    tick();
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    #1;
    if (pc_load !== 1'b1 || pc_src !== 1'b1) begin
      errors++; $display("FAIL branch_load got load %b src %b exp 1 1", pc_load, pc_src);
    end
    checks++;
    tick();
    bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    #1;
    if (retired_cnt !== 4'd1 || bus.imem_req !== 1'b1 || bus.imem_addr !== BASE + BR_OFF) begin
      errors++; $display("FAIL branch_target got cnt %0d req %b addr %h exp 1 1 %h", retired_cnt, bus.imem_req, bus.imem_addr, BASE + BR_OFF);
    end
    checks++;
  endtask

  task automatic test_issue_stall();
    logic [31:0] w0;
    int bad;
    bad = 0;
    fill_mem(0);
    w0 = word_at(BASE);
    do_reset();
    en = 1'b1; bus.imem_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.br_valid = 1'b1; bus.br_taken = 1'b1;
      #1;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w0 || bus.instr_pc !== BASE || pc_load !== 1'b0) bad++;
      tick();
      bus.br_valid = 1'b0;
    end
    if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
    checks++;
    bus.instr_ready = 1'b1; bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    #1;
    if (pc_load !== 1'b1 || pc_src !== 1'b0) begin
      errors++; $display("FAIL stall_accept got load %b src %b exp 1 0", pc_load, pc_src);
    end
    checks++;
    tick();
    bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    #1;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== BASE + 32'd4 || retired_cnt !== 4'd1) begin
      errors++; $display("FAIL stall_next got req %b addr %h cnt %0d exp 1 %h 1", bus.imem_req, bus.imem_addr, retired_cnt, BASE + 32'd4);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    fill_mem(0);
    do_reset();
    en = 1'b1;
    tick();
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    if ({bus.imem_req, bus.instr_valid, pc_load, fetch_err} !== 4'b0 || retired_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_fetch got %b cnt %0d exp 0000 0", {bus.imem_req, bus.instr_valid, pc_load, fetch_err}, retired_cnt);
    end
    checks++;
    tick();
    #1;
    if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch_restart got %b exp 1", bus.imem_req); end
    checks++;
    mem[BASE[7:2]] = NOP;
    mem[BASE[7:2] + 6'd1] = BEQ;
    do_reset();
    en = 1'b1; bus.imem_ready = 1'b1; bus.instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #1;
    if (retired_cnt !== 4'd1 || bus.instr_pc !== BASE + 32'd4 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_resolve_pre got cnt %0d pc %h v %b req %b exp 1 %h 0 0", retired_cnt, bus.instr_pc, bus.instr_valid, bus.imem_req, BASE + 32'd4);
    end
    checks++;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    bus.br_valid = 1'b1;
    #1;
    if ({bus.imem_req, bus.instr_valid, pc_load, pc_src, fetch_err} !== 5'b0 || retired_cnt !== 4'd0 || {bus.instr, bus.instr_pc} !== 64'h0) begin
      errors++; $display("FAIL rst_resolve got %b cnt %0d data %h exp 00000 0 0", {bus.imem_req, bus.instr_valid, pc_load, pc_src, fetch_err}, retired_cnt, {bus.instr, bus.instr_pc});
    end
    checks++;
    bus.br_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int loads;
    logic [3:0] exp_cnt;
    loads = 0;
    fill_mem(0);
    do_reset();
    en = 1'b1; bus.imem_ready = 1'b1; bus.instr_ready = 1'b1;
    for (int c = 0; c < 80 && loads < 17; c++) begin
      #1;
      if (pc_load === 1'b1) loads++;
      tick();
    end
    exp_cnt = 4'(loads % 16);
    if (loads != 17 || retired_cnt !== exp_cnt || retired_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_cnt got %0d after %0d loads exp 1", retired_cnt, loads);
    end
    checks++;
  endtask

  task automatic test_random();
    logic held, awaiting, exp_load, exp_src, fire_fetch;
    logic [31:0] held_word, held_pc;
    int loads;
    held = 1'b0; awaiting = 1'b0; loads = 0;
    held_word = '0; held_pc = '0;
    fill_mem(30);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en              = ($urandom_range(0, 9) != 0);
      bus.imem_ready  = ($urandom_range(0, 9) < 6);
      bus.instr_ready = ($urandom_range(0, 9) < 6);
      bus.br_valid    = ($urandom_range(0, 9) < 4);
      bus.br_taken    = $urandom_range(0, 1) == 1;
      #1;
      exp_load = (held && bus.instr_ready && held_word[6:0] != BR_OPC) || (awaiting && bus.br_valid);
      exp_src  = awaiting && bus.br_valid && bus.br_taken;
      if (bus.instr_valid !== held) begin
        errors++; $display("FAIL rand_valid c%0d got %b exp %b", c, bus.instr_valid, held);
      end
      checks++;
      if (held && (bus.instr !== held_word || bus.instr_pc !== held_pc)) begin
        errors++; $display("FAIL rand_instr c%0d got %h @%h exp %h @%h", c, bus.instr, bus.instr_pc, held_word, held_pc);
      end
      checks++;
      if (bus.imem_req === 1'b1 && (held || awaiting || bus.imem_addr !== pc_in)) begin
        errors++; $display("FAIL rand_fetch c%0d got addr %h busy %b exp addr %h idle", c, bus.imem_addr, held | awaiting, pc_in);
      end
      checks++;
      if (pc_load !== exp_load || (exp_load && pc_src !== exp_src)) begin
        errors++; $display("FAIL rand_load c%0d got %b/%b exp %b/%b", c, pc_load, pc_src, exp_load, exp_src);
      end
      checks++;
      fire_fetch = (bus.imem_req === 1'b1) && bus.imem_ready;
      if (held && bus.instr_ready) begin
        held = 1'b0;
        if (held_word[6:0] == BR_OPC) awaiting = 1'b1;
      end else if (awaiting && bus.br_valid) begin
        awaiting = 1'b0;
      end
      if (fire_fetch) begin
        held = 1'b1;
        held_word = word_at(pc_in);
        held_pc = pc_in;
      end
      if (exp_load) loads++;
      tick();
    end
    bus.br_valid = 1'b0; bus.instr_ready = 1'b0;
    #1;
    if (retired_cnt !== 4'(loads % 16) || loads < 20) begin
      errors++; $display("FAIL rand_retired got %0d exp %0d (loads %0d)", retired_cnt, loads % 16, loads);
    end
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL rand_err got %b exp 0", fetch_err); end
    checks++;
  endtask

  initial begin
    areset = 1'b1;
    en = 1'b0;
    pc_in = BASE;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_imem_delay();
    test_timeout();
    test_branch();
    test_issue_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
